// File: rtl/video_timing_pkg.sv
// Shared timing-set type, NTSC/PAL presets and custom-register map for the raster generator.
package video_timing_pkg;

    localparam int unsigned TimingW = 16;

    typedef logic [TimingW-1:0] tval_t;

    typedef struct packed {
        tval_t h_total;
        tval_t border_start;
        tval_t border_end;
        tval_t hblank_start;
        tval_t hblank_end;
        tval_t hsync_end;
        tval_t lrc_col;
        tval_t prst_col;
        tval_t v_total;
        tval_t vsync_end;
        tval_t vblank_start;
        tval_t vblank_end;
        tval_t vblank_ex_start;
        tval_t vblank_ex_end;
    } timing_t;

    typedef enum logic [1:0] {
        ModeNtsc     = 2'd0,
        ModePal      = 2'd1,
        ModeCustom   = 2'd2,
        ModeReserved = 2'd3
    } mode_e;

    localparam logic [3:0] RegHTotal        = 4'd0;
    localparam logic [3:0] RegBorderStart   = 4'd1;
    localparam logic [3:0] RegBorderEnd     = 4'd2;
    localparam logic [3:0] RegHblankStart   = 4'd3;
    localparam logic [3:0] RegHblankEnd     = 4'd4;
    localparam logic [3:0] RegHsyncEnd      = 4'd5;
    localparam logic [3:0] RegLrcCol        = 4'd6;
    localparam logic [3:0] RegPrstCol       = 4'd7;
    localparam logic [3:0] RegVTotal        = 4'd8;
    localparam logic [3:0] RegVsyncEnd      = 4'd9;
    localparam logic [3:0] RegVblankStart   = 4'd10;
    localparam logic [3:0] RegVblankEnd     = 4'd11;
    localparam logic [3:0] RegVblankExStart = 4'd12;
    localparam logic [3:0] RegVblankExEnd   = 4'd13;

    localparam timing_t NTSC_TIMING = '{
        h_total: 16'd453, border_start: 16'd413, border_end: 16'd93,
        hblank_start: 16'd440, hblank_end: 16'd68, hsync_end: 16'd34,
        lrc_col: 16'd412, prst_col: 16'd418,
        v_total: 16'd262, vsync_end: 16'd3, vblank_start: 16'd258,
        vblank_end: 16'd16, vblank_ex_start: 16'd248, vblank_ex_end: 16'd24
    };

    localparam timing_t PAL_TIMING = '{
        h_total: 16'd453, border_start: 16'd413, border_end: 16'd93,
        hblank_start: 16'd440, hblank_end: 16'd68, hsync_end: 16'd34,
        lrc_col: 16'd412, prst_col: 16'd418,
        v_total: 16'd312, vsync_end: 16'd3, vblank_start: 16'd308,
        vblank_end: 16'd16, vblank_ex_start: 16'd298, vblank_ex_end: 16'd24
    };

    // Reserved and custom modes fall back to NTSC when a preset is required.
    function automatic timing_t preset_timing(mode_e mode);
        return (mode == ModePal) ? PAL_TIMING : NTSC_TIMING;
    endfunction

endpackage

// File: rtl/video_timing_regs.sv
// Custom/staged/active timing sets; the staged set is handed to active only at the frame wrap.
module video_timing_regs
    import video_timing_pkg::*;
#(
    parameter int unsigned HW = 9,
    parameter int unsigned VW = 9,
    parameter int unsigned DW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    mode_i,
    input  logic          cfg_we_i,
    input  logic [3:0]    cfg_addr_i,
    input  logic [DW-1:0] cfg_data_i,
    input  logic          wrap_i,
    output timing_t       active_o,
    output logic          pending_o
);

    timing_t    custom_q, custom_d, active_q, staged;
    logic       pending_q;
    logic [1:0] mode_q;
    mode_e      mode;
    tval_t      h_val, v_val;

    assign mode   = mode_e'(mode_i);
    assign h_val  = tval_t'(cfg_data_i[HW-1:0]);
    assign v_val  = tval_t'(cfg_data_i[VW-1:0]);
    assign staged = (mode == ModeCustom) ? custom_q : preset_timing(mode);

    always_comb begin
        custom_d = custom_q;
        if (cfg_we_i) begin
            case (cfg_addr_i)
                RegHTotal:        custom_d.h_total         = h_val;
                RegBorderStart:   custom_d.border_start    = h_val;
                RegBorderEnd:     custom_d.border_end      = h_val;
                RegHblankStart:   custom_d.hblank_start    = h_val;
                RegHblankEnd:     custom_d.hblank_end      = h_val;
                RegHsyncEnd:      custom_d.hsync_end       = h_val;
                RegLrcCol:        custom_d.lrc_col         = h_val;
                RegPrstCol:       custom_d.prst_col        = h_val;
                RegVTotal:        custom_d.v_total         = v_val;
                RegVsyncEnd:      custom_d.vsync_end       = v_val;
                RegVblankStart:   custom_d.vblank_start    = v_val;
                RegVblankEnd:     custom_d.vblank_end      = v_val;
                RegVblankExStart: custom_d.vblank_ex_start = v_val;
                RegVblankExEnd:   custom_d.vblank_ex_end   = v_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            custom_q  <= NTSC_TIMING;
            active_q  <= preset_timing(mode);
            pending_q <= 1'b0;
            mode_q    <= mode_i;
        end else begin
            custom_q <= custom_d;
            mode_q   <= mode_i;
            if (wrap_i) begin
                active_q <= staged;
            end
            // A change landing on the wrap clock stays pending for the next frame.
            if (cfg_we_i || (mode_i != mode_q)) begin
                pending_q <= 1'b1;
            end else if (wrap_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign active_o  = active_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster column/row counters and timing-strobe decodes driven by the active timing set.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HW         = 9,
    parameter int unsigned VW         = 9,
    parameter int unsigned DW         = 9,
    parameter int unsigned PRESET_COL = 278,
    parameter int unsigned PRESET_ROW = 38
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          preset,
    input  logic [1:0]    mode,
    input  logic          hide_border,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic [HW-1:0] col,
    output logic [VW-1:0] row,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          vblank_ex,
    output logic          border,
    output logic          lrc,
    output logic          prst,
    output logic          vbe,
    output logic          hbs,
    output logic          frame_start,
    output logic          cfg_pending
);

    timing_t       act;
    logic [HW-1:0] col_q, col_d;
    logic [VW-1:0] row_q, row_d;
    logic          col_end, row_end, wrap;

    // >= rather than == so a counter stranded past a shrunk total still wraps.
    assign col_end = col_q >= act.h_total[HW-1:0];
    assign row_end = row_q >= act.v_total[VW-1:0];
    assign wrap    = ce & col_end & row_end;

    video_timing_regs #(
        .HW(HW),
        .VW(VW),
        .DW(DW)
    ) u_regs (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .mode_i     (mode),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .wrap_i     (wrap),
        .active_o   (act),
        .pending_o  (cfg_pending)
    );

    always_comb begin
        col_d = col_q + HW'(1);
        row_d = row_q;
        if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q <= preset ? HW'(PRESET_COL) : '0;
            row_q <= preset ? VW'(PRESET_ROW) : '0;
        end else if (ce) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

    assign hsync     = col_q < act.hsync_end[HW-1:0];
    assign vsync     = row_q < act.vsync_end[VW-1:0];
    assign vblank    = (row_q >= act.vblank_start[VW-1:0]) | (row_q < act.vblank_end[VW-1:0]);
    assign vblank_ex = (row_q >= act.vblank_ex_start[VW-1:0])
                     | (row_q < act.vblank_ex_end[VW-1:0]);
    assign border    = (col_q >= act.border_start[HW-1:0]) | (col_q < act.border_end[HW-1:0]);
    assign hblank    = hide_border ? border
                     : ((col_q >= act.hblank_start[HW-1:0]) | (col_q < act.hblank_end[HW-1:0]));

    // lrc is forced high while reset is held so downstream line logic stays cleared.
    assign lrc         = (col_q == act.lrc_col[HW-1:0]) | ~reset_n;
    assign prst        = col_q == act.prst_col[HW-1:0];
    assign hbs         = col_q == act.hblank_start[HW-1:0];
    assign vbe         = (row_q == act.vblank_end[VW-1:0]) & (col_q == HW'(1));
    assign frame_start = (row_q == '0) & (col_q == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against an array-based raster reference model.
module tb_video_timing_gen;

    localparam int unsigned HW   = 9;
    localparam int unsigned VW   = 9;
    localparam int unsigned DW   = 9;
    localparam int unsigned PCOL = 278;
    localparam int unsigned PROW = 260;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce = 1'b0;
    logic          preset = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          hide_border = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = 4'd0;
    logic [DW-1:0] cfg_data = '0;
    logic [HW-1:0] col;
    logic [VW-1:0] row;
    logic hsync, vsync, hblank, vblank, vblank_ex, border;
    logic lrc, prst, vbe, hbs, frame_start, cfg_pending;

    always #5 clk = ~clk;

    video_timing_gen #(
        .HW(HW), .VW(VW), .DW(DW), .PRESET_COL(PCOL), .PRESET_ROW(PROW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .preset(preset), .mode(mode),
        .hide_border(hide_border), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .col(col), .row(row), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .vblank_ex(vblank_ex), .border(border), .lrc(lrc), .prst(prst), .vbe(vbe), .hbs(hbs),
        .frame_start(frame_start), .cfg_pending(cfg_pending)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: timing sets as plain integer arrays indexed by register number.
    int ntsc[14] = '{453, 413, 93, 440, 68, 34, 412, 418, 262, 3, 258, 16, 248, 24};
    int pal[14]  = '{453, 413, 93, 440, 68, 34, 412, 418, 312, 3, 308, 16, 298, 24};
    int cust[14];
    int act[14];
    int m_col, m_row, m_pend, m_pmode;

    int ce_style = 0;
    int tick = 0;
    int ce_count = 0;

    task automatic model_step();
        int  staged[14];
        bit  chg, wrp;
        if (!reset_n) begin
            m_col = preset ? int'(PCOL) : 0;
            m_row = preset ? int'(PROW) : 0;
            if (mode == 2'd1) act = pal; else act = ntsc;
            cust    = ntsc;
            m_pend  = 0;
            m_pmode = int'(mode);
            return;
        end
        if (mode == 2'd2) staged = cust;
        else if (mode == 2'd1) staged = pal;
        else staged = ntsc;
        chg = cfg_we || (int'(mode) != m_pmode);
        wrp = ce && (m_col >= act[0]) && (m_row >= act[8]);
        if (ce) begin
            if (m_col >= act[0]) begin
                m_col = 0;
                m_row = (m_row >= act[8]) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        if (wrp) begin
            act    = staged;
            m_pend = 0;
        end
        if (chg) m_pend = 1;
        if (cfg_we && cfg_addr < 4'd14) cust[cfg_addr] = int'(cfg_data);
        m_pmode = int'(mode);
    endtask

    function automatic logic [11:0] exp_flags();
        bit hs, vs, hb, vb, vx, bd, lr, pr, ve, hz, fs;
        hs = m_col < act[5];
        vs = m_row < act[9];
        vb = (m_row >= act[10]) || (m_row < act[11]);
        vx = (m_row >= act[12]) || (m_row < act[13]);
        bd = (m_col >= act[1]) || (m_col < act[2]);
        hb = hide_border ? bd : ((m_col >= act[3]) || (m_col < act[4]));
        lr = (m_col == act[6]) || !reset_n;
        pr = m_col == act[7];
        hz = m_col == act[3];
        ve = (m_row == act[11]) && (m_col == 1);
        fs = (m_row == 0) && (m_col == 0);
        return {hs, vs, hb, vb, vx, bd, lr, pr, ve, hz, fs, m_pend[0]};
    endfunction

    function automatic logic [11:0] dut_flags();
        return {hsync, vsync, hblank, vblank, vblank_ex, border,
                lrc, prst, vbe, hbs, frame_start, cfg_pending};
    endfunction

    task automatic cyc();
        case (ce_style)
            0:       ce = (tick % 4) == 0;
            1:       ce = $urandom_range(1) == 1;
            default: ce = 1'b1;
        endcase
        tick++;
        model_step();
        @(posedge clk);
        #1;
        if (ce) ce_count++;
        check("col", 32'(col), m_col);
        check("row", 32'(row), m_row);
        check("flags", 32'(dut_flags()), 32'(exp_flags()));
    endtask

    task automatic do_reset(input bit pre, input logic [1:0] md);
        reset_n = 1'b0;
        preset  = pre;
        mode    = md;
        cfg_we  = 1'b0;
        repeat (3) begin
            cyc();
            check("lrc_in_reset", 32'(lrc), 1);
        end
        reset_n = 1'b1;
        #1;
    endtask

    task automatic write_cfg(input logic [3:0] a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = DW'(d);
        cyc();
        cfg_we = 1'b0;
    endtask

    // Counts ce ticks until the raster is back at col 0 / row 0.
    task automatic run_to_frame(output int n);
        int guard = 0;
        ce_count = 0;
        do begin
            cyc();
            guard++;
        end while (!(frame_start && ce_count > 0) && guard < 20000);
        n = ce_count;
    endtask

    function automatic int rand_val(input logic [3:0] a);
        if (a == 4'd0) return int'($urandom_range(60, 20));
        if (a < 4'd8)  return int'($urandom_range(63));
        if (a == 4'd8) return int'($urandom_range(12, 4));
        if (a < 4'd14) return int'($urandom_range(15));
        return int'($urandom_range(511));
    endfunction

    initial begin
        int  n, guard, vbe_hits, vx_row, vb_row, max_row;
        bit  prev_vx, prev_vb, switched;

        // NTSC from 0/0 with ce every 4th clock.
        ce_style = 0;
        do_reset(1'b0, 2'd0);
        check("rst_col", 32'(col), 0);
        check("rst_row", 32'(row), 0);
        check("rst_flags", 32'(dut_flags()), 32'(12'b1111_1100_0010));
        guard    = 0;
        vbe_hits = 0;
        ce_count = 0;
        while (!(row == 1 && col == 0) && guard < 4000) begin
            cyc();
            guard++;
            if (col == 33) check("hsync_col33", 32'(hsync), 1);
            if (col == 34) check("hsync_col34", 32'(hsync), 0);
            if (col == 411) check("lrc_col411", 32'(lrc), 0);
            if (col == 412) check("lrc_col412", 32'(lrc), 1);
        end
        check("ntsc_line_ce", ce_count, 454);
        ce_style = 2;
        guard = 0;
        while (row != 17 && guard < 12000) begin
            cyc();
            guard++;
            if (row == 16 && col == 1) begin
                check("vbe_r16c1", 32'(vbe), 1);
                vbe_hits++;
            end
            if (row == 16 && col == 2) check("vbe_r16c2", 32'(vbe), 0);
        end
        check("vbe_seen", 32'(vbe_hits > 0), 1);

        // PAL from the preset position, then switch to NTSC mid-frame.
        do_reset(1'b1, 2'd1);
        check("preset_col", 32'(col), PCOL);
        check("preset_row", 32'(row), PROW);
        vx_row   = -1;
        vb_row   = -1;
        max_row  = 0;
        switched = 1'b0;
        prev_vx  = vblank_ex;
        prev_vb  = vblank;
        guard    = 0;
        while (!(row == 0 && col == 0) && guard < 40000) begin
            if (!switched && row == 300) begin
                mode     = 2'd0;
                switched = 1'b1;
                cyc();
                check("pend_on_switch", 32'(cfg_pending), 1);
            end else begin
                cyc();
            end
            if (vblank_ex && !prev_vx && vx_row < 0) vx_row = int'(row);
            if (vblank && !prev_vb && vb_row < 0) vb_row = int'(row);
            if (int'(row) > max_row) max_row = int'(row);
            prev_vx = vblank_ex;
            prev_vb = vblank;
            guard++;
        end
        check("pal_vblank_ex_row", vx_row, 298);
        check("pal_vblank_row", vb_row, 308);
        check("pal_last_row", max_row, 312);
        check("pend_after_switch_wrap", 32'(cfg_pending), 0);
        repeat (600) cyc();

        // Custom timing written mid-frame, applied only at the next wrap.
        ce_style = 1;
        do_reset(1'b1, 2'd2);
        write_cfg(4'd0, 99);
        write_cfg(4'd8, 9);
        check("pend_after_write", 32'(cfg_pending), 1);
        run_to_frame(n);
        check("pend_clear_wrap", 32'(cfg_pending), 0);
        run_to_frame(n);
        check("custom_frame", n, 1000);

        // Write landing on the wrap clock stays pending for one more frame.
        guard = 0;
        while (!(col == 99 && row == 9) && guard < 5000) begin
            cyc();
            guard++;
        end
        ce_style = 2;
        write_cfg(4'd0, 49);
        ce_style = 1;
        check("coinc_pend", 32'(cfg_pending), 1);
        check("coinc_col", 32'(col), 0);
        check("coinc_row", 32'(row), 0);
        run_to_frame(n);
        check("frame_before_apply", n, 1000);
        check("pend_after_apply", 32'(cfg_pending), 0);
        run_to_frame(n);
        check("frame_after_apply", n, 500);

        // Random register traffic, border hiding and brief mode glitches away from the wrap.
        repeat (3000) begin
            int r;
            hide_border = $urandom_range(1) == 1;
            mode        = 2'd2;
            cfg_we      = 1'b0;
            r           = int'($urandom_range(99));
            if (r < 5) begin
                cfg_we   = 1'b1;
                cfg_addr = 4'($urandom_range(15));
                cfg_data = DW'(rand_val(cfg_addr));
            end else if (r < 7 && row < 2) begin
                mode = 2'd3;
            end
            cyc();
        end
        cfg_we = 1'b0;
        mode   = 2'd2;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable, mode-switchable raster timing generator for the Maria video path. It succeeds the fixed NTSC/PAL sync block and drives the same timing strobes (sync, blank, border, line-reset, RC-PLA reset, vblank-end, hblank-start) from a column/row counter pair. Counter widths are parametrised. Timing comes from two built-in presets (NTSC, PAL) or a runtime-writable custom register set. Mode and register changes are staged and take effect only at the frame boundary, so the raster never tears mid-frame.

## Interface
- HW, 9: column counter width.
- VW, 9: row counter width.
- DW, 9: config data width; must be ≥ max(HW, VW).
- PRESET_COL, 278: column loaded at reset when `preset` is high.
- PRESET_ROW, 38: row loaded at reset when `preset` is high.
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- ce  in  1  pixel-clock enable (7.16 MHz tick); counters advance only when high.
- preset  in  1  sampled while reset_n is low; selects PRESET_COL/PRESET_ROW as the start position instead of 0/0.
- mode  in  2  0=NTSC, 1=PAL, 2=custom, 3=reserved (treated as NTSC).
- hide_border  in  1  when high, hblank follows border.
- cfg_we  in  1  custom-register write strobe.
- cfg_addr  in  4  custom-register index.
- cfg_data  in  DW  write data; truncated to HW or VW per register.
- col  out  HW  current column.
- row  out  VW  current row.
- hsync, vsync, hblank, vblank, vblank_ex, border  out  1  level outputs.
- lrc, prst, vbe, hbs, frame_start  out  1  single-ce-cycle strobes.
- cfg_pending  out  1  a staged change is waiting for the frame boundary.

## Operation
- Custom register indices:
  - 0 h_total, 1 border_start, 2 border_end, 3 hblank_start, 4 hblank_end, 5 hsync_end, 6 lrc_col, 7 prst_col (all HW bits).
  - 8 v_total, 9 vsync_end, 10 vblank_start, 11 vblank_end, 12 vblank_ex_start, 13 vblank_ex_end (all VW bits).
  - Writes to indices 14–15 are ignored.
- NTSC preset: 453, 413, 93, 440, 68, 34, 412, 418; 262, 3, 258, 16, 248, 24.
- PAL preset: same as NTSC except v_total=312, vblank_start=308, vblank_ex_start=298.
- Custom registers reset to the NTSC preset.
- Three register sets:
  - custom: written by cfg_we.
  - staged: the preset or custom set selected by `mode`.
  - active: drives all decoding.
- cfg_pending sets on any cfg_we, or on any change of `mode` versus its value on the previous clk.
- At wrap (ce high, col ≥ active h_total, row ≥ active v_total):
  - active ← staged;
  - cfg_pending clears, unless a new write or mode change arrives in the same clk, which wins and keeps it set.
- Counting on each ce:
  - col increments;
  - if col ≥ h_total: col←0, row increments;
  - if additionally row ≥ v_total: row←0.
  - The ≥ comparisons recover from a counter left past a shrunk total.
- Decodes, combinational from col/row and the active set:
  - hsync = col<hsync_end; vsync = row<vsync_end.
  - vblank = row≥vblank_start | row<vblank_end; vblank_ex likewise with the ex pair.
  - border = col≥border_start | col<border_end.
  - hblank = hide_border ? border : (col≥hblank_start | col<hblank_end).
  - lrc = col==lrc_col | !reset_n; prst = col==prst_col; hbs = col==hblank_start.
  - vbe = row==vblank_end & col==1; frame_start = row==0 & col==0.

## Timing
- Reset, while reset_n is low:
  - col/row ← 0/0, or PRESET_COL/PRESET_ROW if `preset` is high.
  - active ← preset selected by `mode`; cfg_pending←0.
- Output values one clk after reset with preset=0:
  - hsync=1, vsync=1, hblank=1, vblank=1, vblank_ex=1, border=1, frame_start=1.
  - lrc=0, prst=0, vbe=0, hbs=0.
- Counters update on the clk edge where ce=1. Decodes are valid the same clk the counters change, with zero added latency.
- A strobe lasts one full ce period, i.e. it stays high across the non-ce clks in between.
- A cfg write becomes visible in active at the next wrap: the first col=0,row=0 frame after the write.
- reset_n mid-frame aborts any staged change and reloads from `mode`.
- ce low for any duration freezes all state; strobes hold their value.

## Structure
- Package `video_timing_pkg` holds:
  - `timing_t` struct with all 14 fields;
  - the NTSC_TIMING and PAL_TIMING constants;
  - the mode enum;
  - the register-index localparams.
- One sub-module, `video_timing_regs`: owns the custom, staged and active sets, cfg_pending, and the wrap handoff.
- The top level holds the counters and decodes.

## Test plan
- NTSC, preset=0, ce every 4th clk → line period 454 ce; frame 263 lines; vbe at row16/col1; lrc at col412; hsync high for cols 0–33.
- PAL → frame 313 lines; vblank rises at row 308; vblank_ex at row 298.
- reset_n low with preset=1 → col=278, row=38 on release; lrc high throughout reset.
- Custom mode, write h_total=99, v_total=9 mid-frame → old timing continues until wrap; then line=100, frame=10; cfg_pending falls at that wrap.
- cfg_we coincident with the wrap → new value staged, cfg_pending stays 1, applied at the following wrap.
- Switch PAL→NTSC while row=300 → completes to row 312, wraps, then the NTSC 263-line frame.
